// File: rtl/seq_pattern_tx_if.sv
// Bus between a pattern requester and seq_pattern_tx.
//   master: drives start/pattern/repeats/gap/abort, observes the serial stream and status
//   slave : the transmitter side (reverse directions)
// The pattern repeat count is named repeats because repeat is a reserved word.
interface seq_pattern_tx_if #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned REP_W = 4,
   parameter int unsigned GAP_W = 3
);
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [REP_W-1:0] repeats;
   logic [GAP_W-1:0] gap;
   logic             abort;
   logic             seq;
   logic             seq_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern, repeats, gap, abort,
      input  seq, seq_valid, busy, done
   );

   modport slave (
      input  start, pattern, repeats, gap, abort,
      output seq, seq_valid, busy, done
   );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first,
// repeated max(repeats,1) times with gap idle cycles between repetitions.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of seq_pattern_tx_if (start/pattern/repeats/gap/abort in,
//         seq/seq_valid/busy/done out, all outputs registered)
module seq_pattern_tx #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned REP_W = 4,
   parameter int unsigned GAP_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   seq_pattern_tx_if.slave     bus
);

   localparam int unsigned CNT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;     // latched pattern for restarts
   logic [PAT_W-1:0] sh_q, sh_d;       // remaining bits, next one at MSB
   logic [CNT_W-1:0] bit_q, bit_d;     // index of the bit currently on seq
   logic [REP_W-1:0] rep_q, rep_d;     // repetitions still to send after this one
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;   // gap cycles left after the current one
   logic             seq_q, seq_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         gcnt_q  <= '0;
         seq_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
         seq_q   <= seq_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      rep_d   = rep_q;
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
      seq_d   = seq_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            seq_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            // abort held with start blocks the start
            if (bus.start && !bus.abort) begin
               pat_d   = bus.pattern;
               gap_d   = bus.gap;
               rep_d   = (bus.repeats == '0) ? '0 : bus.repeats - REP_W'(1);
               sh_d    = bus.pattern << 1;
               seq_d   = bus.pattern[PAT_W-1];
               bit_d   = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               seq_d   = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (bit_q == LAST_BIT) begin
               if (rep_q != '0) begin
                  rep_d = rep_q - REP_W'(1);
                  if (gap_q != '0) begin
                     // first gap cycle is this transition's result
                     state_d = S_GAP;
                     gcnt_d  = gap_q - GAP_W'(1);
                     seq_d   = 1'b0;
                     valid_d = 1'b0;
                  end else begin
                     sh_d  = pat_q << 1;
                     seq_d = pat_q[PAT_W-1];
                     bit_d = '0;
                  end
               end else begin
                  state_d = S_IDLE;
                  seq_d   = 1'b0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else begin
               sh_d  = sh_q << 1;
               seq_d = sh_q[PAT_W-1];
               bit_d = bit_q + CNT_W'(1);
            end
         end

         S_GAP: begin
            if (bus.abort) begin
               state_d = S_IDLE;
               seq_d   = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (gcnt_q == '0) begin
               state_d = S_SHIFT;
               sh_d    = pat_q << 1;
               seq_d   = pat_q[PAT_W-1];
               bit_d   = '0;
               valid_d = 1'b1;
            end else begin
               gcnt_d = gcnt_q - GAP_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            seq_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.seq       = seq_q;
   assign bus.seq_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives a one-bit stream into a sequence detector (the seq input of the detector FSMs). It loads a parallel PAT_W-bit pattern and shifts it out MSB-first, one bit per clock. The pattern can be repeated a programmable number of times, with programmable idle gaps between repetitions. Used as the stimulus source and loopback partner for detector blocks.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
REP_W, 4, width of repeat-count input
GAP_W, 3, width of gap-length input

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request a transmission; sampled only in IDLE
pattern  input  PAT_W  bits to send, MSB first; latched on accepted start
repeat  input  REP_W  number of pattern transmissions; 0 treated as 1; latched on start
gap  input  GAP_W  idle cycles between repetitions; latched on start
abort  input  1  synchronous cancel of current transmission
seq  output  1  serial data bit
seq_valid  output  1  high when seq carries a pattern bit
busy  output  1  high from accepted start until transmission ends
done  output  1  one-cycle pulse after last bit of last repetition

Behaviour:
- All outputs registered. Reset (async, rst=1): state IDLE; seq=0, seq_valid=0, busy=0, done=0; internal shift/bit/repeat/gap counters cleared.
- States: IDLE, SHIFT, GAP.
- IDLE: seq=0, seq_valid=0, busy=0. If start=1 at edge E0: latch pattern, repeat (0->1), gap. After E0: state SHIFT, busy=1, seq_valid=1, seq=pattern[PAT_W-1]. Latency start->first bit = 1 edge.
- SHIFT: each edge presents the next bit (MSB to LSB). Bit counter runs 0..PAT_W-1. On the edge after bit PAT_W-1:
  - If repetitions remain and gap>0: go to GAP. seq=0, seq_valid=0, busy=1.
  - If repetitions remain and gap=0: restart at MSB in SHIFT, back-to-back with no bubble.
  - If this was the last repetition: go to IDLE. busy=0, seq_valid=0, seq=0, done=1 for exactly one cycle.
- GAP: stays for exactly gap cycles with seq=0 and seq_valid=0. The following edge returns to SHIFT with the MSB of the latched pattern.
- Total busy cycles = R*PAT_W + (R-1)*gap, where R = max(repeat,1).
- start while busy: ignored. Latched pattern/repeat/gap are unaffected by input changes during a transmission.
- start while done=1: accepted, because the state is already IDLE. The next transmission's MSB follows immediately.
- abort=1 in SHIFT or GAP: next edge goes to IDLE, seq=0, seq_valid=0, busy=0. done is NOT pulsed. abort has priority over all other transitions.
- abort in IDLE: no effect. If abort and start are both high in IDLE, start is ignored.
- rst mid-transmission: outputs go to reset values immediately (asynchronously). No done pulse.
- Counters never wrap: the repeat counter saturates at its terminal state. A repeat value of 2^REP_W-1 sends exactly that many repetitions.

Test Plan:
- Reset then start with pattern=4'b1011, repeat=1, gap=0 -> seq_valid high 4 cycles, seq=1,0,1,1; busy high 4 cycles; done=1 on the 5th cycle only.
- pattern=4'b1101, repeat=3, gap=2 -> seq stream 1101,00,1101,00,1101 with seq_valid low during the 00 gaps; busy=16 cycles; one done pulse.
- repeat=0, pattern=4'b0110 -> identical to repeat=1 (4 bits, 1 done). repeat=2, gap=0 -> 8 contiguous valid bits 01100110.
- Start accepted, change pattern and pulse start again during SHIFT -> output still the original latched pattern; no restart.
- abort asserted during 2nd bit of repetition 2 of 3 -> seq_valid=0, busy=0 next cycle; done never pulses. A new start afterwards transmits correctly.
- rst asserted mid-GAP between clock edges -> outputs zero immediately. After release, start with pattern=4'b1001 transmits 1,0,0,1 normally.
